// File: rtl/byte_unstriping.sv
// -----------------------------------------------------------------------------
// byte_unstriping
//   Receive-side lane merger. Two byte lanes (lane 0 = even stream positions,
//   lane 1 = odd stream positions) each feed a small elastic FIFO that absorbs
//   inter-lane skew. A single lane selector alternates between the FIFOs,
//   popping one byte per clk_2f cycle, so the original byte order is restored.
//   The selector never skips an empty lane: if the lane it points at is empty
//   the output simply stalls, so ordering holds even under heavy skew.
//
// Ports
//   clk_2f_i        : single clock, all state on posedge
//   reset_i         : asynchronous, active-low; clears all control state
//   lane_0_i        : lane 0 byte          valid_0_i : lane 0 push strobe
//   lane_1_i        : lane 1 byte          valid_1_i : lane 1 push strobe
//   data_out_o      : reassembled byte (holds its last value while stalled)
//   valid_out_o     : data_out_o qualifier, one byte per cycle
//   sel_lane_o      : lane the next pop will read
//   err_overflow_o  : sticky, a push hit a full FIFO with no same-cycle pop
//   level_0_o       : lane 0 FIFO occupancy (0..DEPTH)
//   level_1_o       : lane 1 FIFO occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module byte_unstriping #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  clk_2f_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] lane_0_i,
    input  logic                  valid_0_i,
    input  logic [DATA_WIDTH-1:0] lane_1_i,
    input  logic                  valid_1_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  valid_out_o,
    output logic                  sel_lane_o,
    output logic                  err_overflow_o,
    output logic [PTR_W:0]        level_0_o,
    output logic [PTR_W:0]        level_1_o
);

    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

    // Per-lane FIFO storage and pointers, index 0/1 = lane number.
    logic [DATA_WIDTH-1:0] mem_q    [2][DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q [2];
    logic [PTR_W-1:0]      wr_ptr_d [2];
    logic [PTR_W-1:0]      rd_ptr_q [2];
    logic [PTR_W-1:0]      rd_ptr_d [2];
    logic [PTR_W:0]        level_q  [2];
    logic [PTR_W:0]        level_d  [2];

    logic [DATA_WIDTH-1:0] lane_din [2];
    logic [1:0]            push_req;
    logic [1:0]            push_ok;
    logic [1:0]            pop;
    logic [1:0]            drop;

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  sel_q, sel_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] head;

    assign push_req = {valid_1_i, valid_0_i};

    // Head of the currently selected FIFO, read from pre-edge state so a byte
    // written on this edge can only be popped on a later one.
    assign head = mem_q[sel_q][rd_ptr_q[sel_q]];

    always_comb begin
        lane_din[0] = lane_0_i;
        lane_din[1] = lane_1_i;
        push_ok     = '0;
        pop         = '0;
        drop        = '0;
        for (int k = 0; k < 2; k++) begin
            pop[k]      = (sel_q == 1'(k)) && (level_q[k] != '0);
            // A full FIFO still takes a push when its head leaves on the same
            // edge: the write lands in the slot the pop just vacated.
            push_ok[k]  = push_req[k] && ((level_q[k] != FULL_LVL) || pop[k]);
            drop[k]     = push_req[k] && !push_ok[k];
            wr_ptr_d[k] = push_ok[k] ? wr_ptr_q[k] + PTR_W'(1) : wr_ptr_q[k];
            rd_ptr_d[k] = pop[k]     ? rd_ptr_q[k] + PTR_W'(1) : rd_ptr_q[k];
            case ({push_ok[k], pop[k]})
                2'b10:   level_d[k] = level_q[k] + (PTR_W+1)'(1);
                2'b01:   level_d[k] = level_q[k] - (PTR_W+1)'(1);
                default: level_d[k] = level_q[k];
            endcase
        end
    end

    // Output stage: a pop toggles the selector; an empty selected lane stalls
    // and data_out keeps its previous byte.
    always_comb begin
        valid_out_d = |pop;
        data_out_d  = (|pop) ? head : data_out_q;
        sel_d       = sel_q ^ (|pop);
        err_d       = err_q | (|drop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk_2f_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                level_q[k]  <= '0;
            end
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            sel_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                level_q[k]  <= level_d[k];
            end
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            sel_q       <= sel_d;
            err_q       <= err_d;
        end
    end

    // NOTE: FIFO storage is deliberately left out of reset; stale contents are
    // unreachable once the pointers and levels are cleared, and a reset-free
    // array maps onto plain register-file/RAM cells.
    always_ff @(posedge clk_2f_i) begin
        for (int k = 0; k < 2; k++) begin
            if (push_ok[k]) begin
                mem_q[k][wr_ptr_q[k]] <= lane_din[k];
            end
        end
    end

    assign data_out_o     = data_out_q;
    assign valid_out_o    = valid_out_q;
    assign sel_lane_o     = sel_q;
    assign err_overflow_o = err_q;
    assign level_0_o      = level_q[0];
    assign level_1_o      = level_q[1];

endmodule

// File: tb/tb_byte_unstriping.sv
// -----------------------------------------------------------------------------
// tb_byte_unstriping
//   Directed bench for byte_unstriping. Expected output bytes are queued in
//   stream order as each scenario is set up and popped whenever a cycle is
//   expected to carry valid_out. Levels, selector and overflow flag are
//   compared against hand-derived constants at chosen points.
// -----------------------------------------------------------------------------
module tb_byte_unstriping;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic          clk_2f_i = 1'b0;
    logic          reset_i  = 1'b0;
    logic [DW-1:0] lane_0_i = '0;
    logic          valid_0_i = 1'b0;
    logic [DW-1:0] lane_1_i = '0;
    logic          valid_1_i = 1'b0;
    logic [DW-1:0] data_out_o;
    logic          valid_out_o;
    logic          sel_lane_o;
    logic          err_overflow_o;
    logic [PTR_W:0] level_0_o;
    logic [PTR_W:0] level_1_o;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_data = '0;

    byte_unstriping #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .PTR_W     (PTR_W)
    ) dut (
        .clk_2f_i      (clk_2f_i),
        .reset_i       (reset_i),
        .lane_0_i      (lane_0_i),
        .valid_0_i     (valid_0_i),
        .lane_1_i      (lane_1_i),
        .valid_1_i     (valid_1_i),
        .data_out_o    (data_out_o),
        .valid_out_o   (valid_out_o),
        .sel_lane_o    (sel_lane_o),
        .err_overflow_o(err_overflow_o),
        .level_0_o     (level_0_o),
        .level_1_o     (level_1_o)
    );

    always #5 clk_2f_i = ~clk_2f_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push0(input logic [DW-1:0] b);
        lane_0_i  = b;
        valid_0_i = 1'b1;
    endtask

    task automatic push1(input logic [DW-1:0] b);
        lane_1_i  = b;
        valid_1_i = 1'b1;
    endtask

    // One clock edge; strobes are single-cycle so they are dropped right after.
    // With exp_v set, the next queued byte must appear; otherwise data_out must
    // still hold the last byte delivered.
    task automatic tick(input logic exp_v);
        logic [DW-1:0] e;
        @(posedge clk_2f_i);
        #1;
        valid_0_i = 1'b0;
        valid_1_i = 1'b0;
        check("valid_out", 32'(valid_out_o), 32'(exp_v));
        if (exp_v) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("data_out", 32'(data_out_o), 32'(e));
                last_data = e;
            end
        end else begin
            check("data_hold", 32'(data_out_o), 32'(last_data));
        end
    endtask

    task automatic check_state(input string tag, input logic [PTR_W:0] l0,
                               input logic [PTR_W:0] l1, input logic sel,
                               input logic err);
        check({tag, "_level_0"}, 32'(level_0_o), 32'(l0));
        check({tag, "_level_1"}, 32'(level_1_o), 32'(l1));
        check({tag, "_sel_lane"}, 32'(sel_lane_o), 32'(sel));
        check({tag, "_err_overflow"}, 32'(err_overflow_o), 32'(err));
    endtask

    // Pulse reset between clock edges and flush the scoreboard.
    task automatic do_reset();
        @(posedge clk_2f_i);
        #2;
        reset_i = 1'b0;
        #1;
        check("rst_data_out", 32'(data_out_o), 32'd0);
        check("rst_valid_out", 32'(valid_out_o), 32'd0);
        check_state("rst", 3'd0, 3'd0, 1'b0, 1'b0);
        exp_q.delete();
        last_data = '0;
        @(posedge clk_2f_i);
        #1;
        reset_i = 1'b1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #3;
        check("init_data_out", 32'(data_out_o), 32'd0);
        check("init_valid_out", 32'(valid_out_o), 32'd0);
        check_state("init", 3'd0, 3'd0, 1'b0, 1'b0);
        @(posedge clk_2f_i);
        #1;
        reset_i = 1'b1;

        // ---------------- ordering ----------------
        exp_q.push_back(8'hFF); exp_q.push_back(8'hEE);
        exp_q.push_back(8'hDD); exp_q.push_back(8'hCC);
        push0(8'hFF); tick(1'b0);
        check_state("ord_c0", 3'd1, 3'd0, 1'b0, 1'b0);
        push1(8'hEE); tick(1'b1);
        push0(8'hDD); tick(1'b1);
        push1(8'hCC); tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        check_state("ord_end", 3'd0, 3'd0, 1'b0, 1'b0);

        // ---------------- skew: lane 1 three cycles early ----------------
        exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        push1(8'h03); tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        check_state("skew_wait", 3'd0, 3'd1, 1'b0, 1'b0);
        push0(8'h02); tick(1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        check_state("skew_end", 3'd0, 3'd0, 1'b0, 1'b0);

        // ---------------- stall on empty lane 1 ----------------
        exp_q.push_back(8'h07); exp_q.push_back(8'h08);
        push0(8'h07); tick(1'b0);
        tick(1'b1);
        check("stall_sel_a", 32'(sel_lane_o), 32'd1);
        tick(1'b0);
        check("stall_sel_b", 32'(sel_lane_o), 32'd1);
        push1(8'h08); tick(1'b0);
        check("stall_sel_c", 32'(sel_lane_o), 32'd1);
        tick(1'b1);
        check("stall_sel_end", 32'(sel_lane_o), 32'd0);

        // ---------------- overflow ----------------
        // sel_lane is 0, so 10 leaves on the next edge; 11..14 then fill the
        // FIFO and the sixth byte (15) is the one that overflows.
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20); exp_q.push_back(8'h11);
        exp_q.push_back(8'h21); exp_q.push_back(8'h12);
        exp_q.push_back(8'h22); exp_q.push_back(8'h13);
        exp_q.push_back(8'h23); exp_q.push_back(8'h14);
        push0(8'h10); tick(1'b0);
        push0(8'h11); tick(1'b1);
        push0(8'h12); tick(1'b0);
        push0(8'h13); tick(1'b0);
        push0(8'h14); tick(1'b0);
        check_state("ovf_full", 3'd4, 3'd0, 1'b1, 1'b0);
        push0(8'h15); tick(1'b0);
        check_state("ovf_drop", 3'd4, 3'd0, 1'b1, 1'b1);
        push1(8'h20); tick(1'b0);
        push1(8'h21); tick(1'b1);
        push1(8'h22); tick(1'b1);
        push1(8'h23); tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        check_state("ovf_end", 3'd0, 3'd0, 1'b1, 1'b1);

        // ---------------- full plus same-cycle pop ----------------
        do_reset();
        exp_q.push_back(8'h30); exp_q.push_back(8'h40);
        exp_q.push_back(8'h31); exp_q.push_back(8'h41);
        exp_q.push_back(8'h32);
        push0(8'h30); tick(1'b0);
        push0(8'h31); tick(1'b1);
        push0(8'h32); tick(1'b0);
        push0(8'h33); tick(1'b0);
        push0(8'h34); tick(1'b0);
        push1(8'h40); tick(1'b0);
        push1(8'h41); tick(1'b1);
        check_state("fpop_pre", 3'd4, 3'd1, 1'b0, 1'b0);
        push0(8'h35); tick(1'b1);
        check_state("fpop_post", 3'd4, 3'd1, 1'b1, 1'b0);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        check_state("fpop_end", 3'd3, 3'd0, 1'b1, 1'b0);

        // ---------------- reset mid-operation ----------------
        do_reset();
        exp_q.push_back(8'h60); exp_q.push_back(8'h61);
        push1(8'h61); tick(1'b0);
        push0(8'h60); push1(8'h63); tick(1'b0);
        push0(8'h62); tick(1'b1);
        push0(8'h64); tick(1'b1);
        check_state("mid_pre", 3'd2, 3'd1, 1'b0, 1'b0);
        do_reset();
        exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
        push0(8'hAA); tick(1'b0);
        push1(8'hBB); tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        check_state("mid_end", 3'd0, 3'd0, 1'b0, 1'b0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
